// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD host sequencer: default sizing and the sequencer state encoding.
package gcd_pkg;

  localparam int unsigned DefaultWidth   = 16;
  localparam int unsigned DefaultTimeout = 1024;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StLoadA,
    StLoadB,
    StWait,
    StResp
  } gcd_state_e;

endpackage

// File: rtl/gcd_timeout_counter.sv
// Bounded wait timer: counts enabled cycles from zero and flags the last permitted cycle.
module gcd_timeout_counter
  import gcd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Holding at the last value keeps the counter from wrapping even if en lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LastCnt);

endmodule

// File: rtl/gcd_host_sequencer.sv
// Initiator for the GCD core start/data_in/done protocol: screens zero operands, serialises A then B,
// waits for done under a timeout and returns the result over a valid/ready response port.
module gcd_host_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH          = DefaultWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  output logic             core_clr,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             err_q, err_d;
  logic             timer_expired;

  gcd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == StLoadB),
    .en     (state_q == StWait),
    .expired(timer_expired)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    err_d   = err_q;
    unique case (state_q)
      StClear: state_d = StIdle;
      StIdle: begin
        if (req_valid) begin
          a_d   = req_a;
          b_d   = req_b;
          gcd_d = '0;
          // A zero operand would never converge in the core, so answer without starting it.
          if (req_a == '0 || req_b == '0) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StLoadA;
          end
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StWait;
      StWait: begin
        if (core_done) begin
          gcd_d   = core_result;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_expired) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StClear;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
    end
  end

  // Operand bus carries A for the start cycle, then B until the result is taken.
  always_comb begin
    core_data = '0;
    unique case (state_q)
      StLoadA:        core_data = a_q;
      StLoadB, StWait: core_data = b_q;
      default:        core_data = '0;
    endcase
  end

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign core_start = (state_q == StLoadA);
  assign core_clr   = (state_q == StClear);
  assign rsp_gcd    = gcd_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Self-checking bench: behavioural subtract-loop core, Euclid scoreboard and directed scenarios.
module tb_gcd_host_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_gcd;
  logic         rsp_err;
  logic         core_start;
  logic [W-1:0] core_data;
  logic         core_clr;
  logic         core_done;
  logic [W-1:0] core_result;

  always #5 clk = ~clk;

  gcd_host_sequencer #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_gcd    (rsp_gcd),
    .rsp_err    (rsp_err),
    .core_start (core_start),
    .core_data  (core_data),
    .core_clr   (core_clr),
    .core_done  (core_done),
    .core_result(core_result)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_clr = 0;
  int n_start = 0;
  int n_rsp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural GCD core: latch A on start, B the cycle after, then subtract until equal.
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           m_phase = 0;
  int           m_run = 0;
  int           stall = 0;
  bit           hang = 1'b0;

  always @(posedge clk) begin
    if (rst || core_clr) begin
      m_phase <= 0;
      m_run   <= 0;
    end else if (core_start) begin
      m_a     <= core_data;
      m_phase <= 1;
    end else if (m_phase == 1) begin
      m_b     <= core_data;
      m_phase <= 2;
      m_run   <= 0;
    end else if (m_phase == 2 && !core_done) begin
      m_run <= m_run + 1;
      if (m_a > m_b) m_a <= m_a - m_b;
      else if (m_b > m_a) m_b <= m_b - m_a;
    end
  end

  assign core_done   = (m_phase == 2) && (m_a == m_b) && (m_run >= stall) && !hang;
  assign core_result = m_a;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (core_clr) n_clr <= n_clr + 1;
    if (core_start) n_start <= n_start + 1;
  end

  // Expected response {err, gcd} for one request.
  function automatic logic [W:0] ref_rsp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit no_done);
    logic [W-1:0] x, y, t;
    if (a == '0 || b == '0 || no_done) return {1'b1, {W{1'b0}}};
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return {1'b0, x};
  endfunction

  logic [W:0]   exp_q[$];
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_gcd;
  logic         prev_err;

  // Scoreboard and protocol checks, sampled on the falling edge.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (exp_q.size() != 0) chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (core_start) chk("start_without_req", 32'(exp_q.size() != 0), 32'd1);
      if (prev_hold) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_gcd", 32'(rsp_gcd), 32'(prev_gcd));
        chk("hold_err", 32'(rsp_err), 32'(prev_err));
      end
      if (req_valid && req_ready) exp_q.push_back(ref_rsp(req_a, req_b, hang));
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_gcd", 32'(rsp_gcd), 32'(e[W-1:0]));
          chk("sb_err", 32'(rsp_err), 32'(e[W]));
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_gcd  = rsp_gcd;
      prev_err  = rsp_err;
    end
  end

  // Returns the handshake cycle index.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    bit got = 1'b0;
    acc = -1;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
  endtask

  // Returns the first rsp_valid cycle and first core_done cycle (-1 if none).
  task automatic wait_rsp(output int rc, output int dc);
    bit got = 1'b0;
    rc = -1;
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_done && dc < 0) dc = cyc;
      if (rsp_valid) begin
        rc  = cyc;
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("rsp_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, dc, c0, s0, k;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    chk("ref_12_8", 32'(ref_rsp(16'd12, 16'd8, 1'b0)), 32'h0004);
    chk("ref_0_5", 32'(ref_rsp(16'd0, 16'd5, 1'b0)), 32'h10000);
    chk("ref_48_18", 32'(ref_rsp(16'd48, 16'd18, 1'b0)), 32'h0006);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_core_clr", 32'(core_clr), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_gcd", 32'(rsp_gcd), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_core_data", 32'(core_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("clear_after_rst", 32'(core_clr), 32'd1);
    @(negedge clk);
    chk("idle_clr_low", 32'(core_clr), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);

    // 12,8: operand serialisation
    send(16'd12, 16'd8, acc);
    c0 = n_clr;
    @(negedge clk);
    chk("a_start", 32'(core_start), 32'd1);
    chk("a_data", 32'(core_data), 32'd12);
    @(negedge clk);
    chk("b_start", 32'(core_start), 32'd0);
    chk("b_data", 32'(core_data), 32'd8);
    wait_rsp(rc, dc);
    chk("g12_8_gcd", 32'(rsp_gcd), 32'd4);
    chk("g12_8_err", 32'(rsp_err), 32'd0);
    chk("g12_8_lat", 32'(rc - acc), 32'd6);
    repeat (2) @(posedge clk);
    #1;
    chk("g12_8_clr_pulse", 32'(n_clr - c0), 32'd1);

    // 7,7: done on first WAIT cycle
    send(16'd7, 16'd7, acc);
    wait_rsp(rc, dc);
    chk("g7_gcd", 32'(rsp_gcd), 32'd7);
    chk("g7_err", 32'(rsp_err), 32'd0);
    chk("g7_done_to_valid", 32'(rc - dc), 32'd1);
    chk("g7_lat", 32'(rc - acc), 32'd4);

    // 0,5: screened, core never started
    s0 = n_start;
    send(16'd0, 16'd5, acc);
    wait_rsp(rc, dc);
    chk("zero_lat", 32'(rc - acc), 32'd1);
    chk("zero_gcd", 32'(rsp_gcd), 32'd0);
    chk("zero_err", 32'(rsp_err), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("zero_no_start", 32'(n_start - s0), 32'd0);

    // Timeout: core never signals done
    hang = 1'b1;
    send(16'd3, 16'd5, acc);
    c0 = n_clr;
    wait_rsp(rc, dc);
    chk("to_lat", 32'(rc - acc), 32'(3 + TO));
    chk("to_gcd", 32'(rsp_gcd), 32'd0);
    chk("to_err", 32'(rsp_err), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("to_clr_pulse", 32'(n_clr - c0), 32'd1);
    hang = 1'b0;

    // Response back-pressure
    rsp_ready = 1'b0;
    send(16'd9, 16'd6, acc);
    wait_rsp(rc, dc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_gcd", 32'(rsp_gcd), 32'd3);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (req_ready) begin
        k = i;
        break;
      end
    end
    chk("bp_idle_delay", 32'(k), 32'd3);

    // Reset mid-WAIT aborts the request
    stall = 8;
    send(16'd48, 16'd18, acc);
    repeat (3) @(negedge clk);
    chk("abort_in_wait_data", 32'(core_data), 32'd18);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_clr", 32'(core_clr), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_gcd", 32'(rsp_gcd), 32'd0);
    chk("abort_rsp_err", 32'(rsp_err), 32'd0);
    chk("abort_core_data", 32'(core_data), 32'd0);
    @(negedge clk);
    chk("abort_idle", 32'(req_ready), 32'd1);
    stall = 0;
    send(16'd48, 16'd18, acc);
    wait_rsp(rc, dc);
    chk("g48_18_gcd", 32'(rsp_gcd), 32'd6);
    chk("g48_18_err", 32'(rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    chk("rsp_count", 32'(n_rsp), 32'd6);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
